// File: rtl/fifo_if.sv
// +----------------------------------------------------------------------+
// | FifoIO: signal bundle between a fifo and its producer/consumer.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface FifoIO #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_SIZE  = 4
);

  logic                         wr_en;
  logic [DATA_WIDTH-1:0]        wr_data;
  logic                         rd_en;
  logic [DATA_WIDTH-1:0]        rd_data;
  logic                         full;
  logic                         empty;
  logic [$clog2(FIFO_SIZE):0]   count;
  logic                         overflow;
  logic                         underflow;

  modport fifo (
    input  wr_en, wr_data, rd_en,
    output rd_data, full, empty, count, overflow, underflow
  );

  // Producer owns the write side, consumer owns the read side.
  modport producer (
    output wr_en, wr_data,
    input  rd_en, rd_data, full, empty, count, overflow, underflow
  );

  modport consumer (
    output rd_en,
    input  wr_en, wr_data, rd_data, full, empty, count, overflow, underflow
  );

endinterface

`default_nettype wire

// File: rtl/fifo.sv
// +----------------------------------------------------------------------+
// | fifo: single-clock first-word-fall-through FIFO on a FifoIO bundle.  |
// | Optional sticky overflow/underflow flags: define FIFO_ERR_FLAGS_EN.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_SIZE  = 4
) (
  input  logic clk,
  input  logic rst,
  FifoIO.fifo  fifo_io
);

  localparam int c_PTR_W = $clog2(FIFO_SIZE);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_SIZE];
  logic [c_PTR_W-1:0]    r_wp;
  logic [c_PTR_W-1:0]    r_rp;
  logic [c_CNT_W-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == c_CNT_W'(FIFO_SIZE));
  assign w_empty = (r_count == '0);

  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign w_push = fifo_io.wr_en && (!w_full || fifo_io.rd_en);
  assign w_pop  = fifo_io.rd_en && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wp] <= fifo_io.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + c_PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

  assign fifo_io.rd_data = w_empty ? '0 : r_mem[r_rp];
  assign fifo_io.full    = w_full;
  assign fifo_io.empty   = w_empty;
  assign fifo_io.count   = r_count;

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (fifo_io.wr_en && w_full && !fifo_io.rd_en) begin
        r_overflow <= 1'b1;
      end
      if (fifo_io.rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign fifo_io.overflow  = r_overflow;
  assign fifo_io.underflow = r_underflow;
`else
  assign fifo_io.overflow  = 1'b0;
  assign fifo_io.underflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo.sv
// +----------------------------------------------------------------------+
// | tb_fifo: self-checking bench for fifo (vector table + scoreboard).   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  typedef struct {
    logic          we;
    logic [DW-1:0] wd;
    logic          re;
    int            exp_count;
    int            exp_rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  FifoIO #(.DATA_WIDTH(DW), .FIFO_SIZE(DEPTH)) bus ();

  fifo #(.DATA_WIDTH(DW), .FIFO_SIZE(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .fifo_io (bus.fifo)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] q [$];
  logic          ovf = 1'b0;
  logic          unf = 1'b0;
  vec_t          vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(bus.count), 32'(q.size()));
    check({tag, "_empty"}, 32'(bus.empty), 32'(q.size() == 0));
    check({tag, "_full"},  32'(bus.full),  32'(q.size() == DEPTH));
    check({tag, "_rd_data"}, 32'(bus.rd_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    check({tag, "_overflow"},  32'(bus.overflow),  32'(ovf));
    check({tag, "_underflow"}, 32'(bus.underflow), 32'(unf));
  endtask

  // One clock cycle of stimulus; popped data is scored against the model queue.
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re, input string tag);
    bit was_empty, was_full, pop_ok, push_ok;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    #1;
    was_empty = (q.size() == 0);
    was_full  = (q.size() == DEPTH);
    if (re && !was_empty) check({tag, "_pop_data"}, 32'(bus.rd_data), 32'(q[0]));
    pop_ok  = re && !was_empty;
    push_ok = we && (!was_full || re);
`ifdef FIFO_ERR_FLAGS_EN
    if (we && was_full && !re) ovf = 1'b1;
    if (re && was_empty)       unf = 1'b1;
`endif
    if (pop_ok)  void'(q.pop_front());
    if (push_ok) q.push_back(wd);
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic do_reset(input int cycles, input logic we);
    rst         = 1'b1;
    bus.wr_en   = we;
    bus.wr_data = 16'hDEAD;
    bus.rd_en   = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.wr_en = 1'b0;
    q.delete();
    ovf = 1'b0;
    unf = 1'b0;
    check_state("reset");
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;

    // Fill to full, drop a write, then drain past empty.
    vecs[0] = '{1'b1, 16'd0, 1'b0, 1, 0};
    vecs[1] = '{1'b1, 16'd1, 1'b0, 2, 0};
    vecs[2] = '{1'b1, 16'd2, 1'b0, 3, 0};
    vecs[3] = '{1'b1, 16'd3, 1'b0, 4, 0};
    vecs[4] = '{1'b1, 16'd4, 1'b0, 4, 0};
    vecs[5] = '{1'b0, 16'd0, 1'b1, 3, 1};
    vecs[6] = '{1'b0, 16'd0, 1'b1, 2, 2};
    vecs[7] = '{1'b0, 16'd0, 1'b1, 1, 3};
    vecs[8] = '{1'b0, 16'd0, 1'b1, 0, 0};
    vecs[9] = '{1'b0, 16'd0, 1'b1, 0, 0};

    do_reset(3, 1'b0);

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].we, vecs[i].wd, vecs[i].re, "vec");
      check("vec_tbl_count", 32'(bus.count),   32'(vecs[i].exp_count));
      check("vec_tbl_rd",    32'(bus.rd_data), 32'(vecs[i].exp_rd));
    end

    // Wrap-around with random interleaved pops, never reaching full.
    do_reset(1, 1'b0);
    for (int v = 10; v < 20; v++) begin
      logic re;
      re = ($urandom_range(0, 1) == 1) || (q.size() >= DEPTH - 1);
      step(1'b1, DW'(v), re, "wrap");
    end
    for (int k = 0; k < 12 && q.size() != 0; k++) step(1'b0, '0, 1'b1, "wrap_drain");
    check("wrap_drained", 32'(q.size()), 32'd0);

    // Full with simultaneous push/pop, then drain; 9 must come out last.
    for (int v = 20; v < 24; v++) step(1'b1, DW'(v), 1'b0, "full_fill");
    step(1'b1, 16'd9, 1'b1, "full_pp");
    check("full_pp_count", 32'(bus.count),   32'd4);
    check("full_pp_head",  32'(bus.rd_data), 32'd21);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, "full_drain");
    check("full_last_is_9", 32'(bus.rd_data), 32'd9);
    step(1'b0, '0, 1'b1, "full_drain");

    // Empty with simultaneous push/pop: only the push lands.
    step(1'b1, 16'd7, 1'b1, "empty_pp");
    check("empty_pp_count", 32'(bus.count),   32'd1);
    check("empty_pp_rd",    32'(bus.rd_data), 32'd7);
    step(1'b0, '0, 1'b1, "empty_drain");

    // Reset mid-operation with wr_en asserted discards everything.
    step(1'b1, 16'd30, 1'b0, "prerst");
    step(1'b1, 16'd31, 1'b0, "prerst");
    do_reset(1, 1'b1);
    step(1'b1, 16'd5, 1'b0, "postrst");
    check("postrst_rd", 32'(bus.rd_data), 32'd5);
    bus.wr_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo.md
# fifo

Synchronous single-clock first-in/first-out buffer, connected through the `FifoIO` interface bundle. It decouples a producer from a consumer in the NoC datapath, for example router input buffering. Read data is first-word-fall-through: the head entry is visible on `rd_data` before it is popped. Writes to a full FIFO and reads from an empty FIFO are ignored.

## Interface
Parameters:
- `DATA_WIDTH`, default 16: payload width in bits. Applies to both `FIFO` and `FifoIO`.
- `FIFO_SIZE`, default 4: depth in entries. Must be a power of two, ≥ 2.

Ports:
- `clk`  input  1  clock; all state updates on its rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `fifo_io`  interface  `FifoIO.fifo`  bundle, modport `fifo`.

`FifoIO #(DATA_WIDTH)` signals (direction given as seen by the FIFO):
- `wr_en`  in  1  push request.
- `wr_data`  in  DATA_WIDTH  push payload.
- `rd_en`  in  1  pop request.
- `rd_data`  out  DATA_WIDTH  head entry.
- `full`  out  1  count == FIFO_SIZE.
- `empty`  out  1  count == 0.
- `count`  out  $clog2(FIFO_SIZE)+1  current occupancy.
- `overflow`  out  1  sticky flag; see Configuration.
- `underflow`  out  1  sticky flag; see Configuration.

`FifoIO` also provides modports `producer` and `consumer`, which are the mirror directions of the signals above.

## Operation
- Storage is an array of FIFO_SIZE × DATA_WIDTH registers, with write pointer `wp` and read pointer `rp`, each $clog2(FIFO_SIZE) bits wide.
- Pointers wrap naturally modulo FIFO_SIZE. Occupancy is held in a registered `count`.
- Push accepted = `wr_en && (!full || rd_en)`. On an accepted push: `mem[wp] <= wr_data`, `wp <= wp+1`.
- Pop accepted = `rd_en && !empty`. On an accepted pop: `rp <= rp+1`.
- Count update:
  - push only: +1.
  - pop only: −1.
  - both, or neither: unchanged.
- Full with `wr_en` and `rd_en` both high: both are accepted. The head is popped and the new word is appended; count stays FIFO_SIZE.
- Empty with `wr_en` and `rd_en` both high: only the push is accepted; count becomes 1. The read is ignored.
- `wr_en` while full without `rd_en`: the write is dropped and memory/pointers are unchanged.
- `rd_en` while empty: ignored.
- `rd_data` is combinational. It equals `mem[rp]` when `!empty` and all-zero when `empty`.
- `full`, `empty` and `count` are derived from registered state only, with no combinational path from `wr_en`/`rd_en`.
- Reset clears `wp`, `rp`, `count` and the flags. Memory contents are not cleared.
- Values after reset: `empty=1`, `full=0`, `count=0`, `rd_data=0`, `overflow=0`, `underflow=0`.
- Reset asserted mid-operation discards all stored entries at the next rising edge. Any `wr_en`/`rd_en` in that cycle is ignored.

## Timing
- Push latency: a word accepted at edge N appears on `rd_data` (if it is the head) and is reflected in `count`/`empty`/`full` immediately after edge N.
- Pop handshake: the consumer samples `rd_data` in the cycle in which it asserts `rd_en`. The next entry, or 0 if the FIFO is now empty, appears after that edge.
- Sustained throughput is one push and one pop per cycle.
- Flags update on the same edge as the event that sets them.

## Configuration
- Macro `FIFO_ERR_FLAGS_EN` selects the error-flag logic.
- Defined:
  - `overflow` goes high on any edge with a dropped write (`wr_en && full && !rd_en`).
  - `underflow` goes high on any edge with `rd_en && empty`.
  - Both flags are sticky until `rst`.
- Undefined: `overflow` and `underflow` are tied to 0, and no flag registers are built.

## Test plan
Default parameters are DATA_WIDTH=16, FIFO_SIZE=4.
1. Hold `rst`=1 for 3 cycles, then release → `empty`=1, `full`=0, `count`=0, `rd_data`=0, flags 0.
2. Push 0,1,2,3 on consecutive cycles → `full`=1, `count`=4, `rd_data`=0. Then push 4 alone → dropped, `count`=4; `overflow`=1 only with `FIFO_ERR_FLAGS_EN`.
3. Pop 4 times from the state left by scenario 2 → `rd_data` sampled in the pop cycles is 0,1,2,3. Then `empty`=1 and `rd_data`=0. A 5th pop leaves `count`=0 and sets `underflow`=1 (with macro).
4. Wrap-around: push 10..19 with random pops interleaved (both pointers wrap at least twice) → pops return 10..19 in order with no loss while never full.
5. Full plus simultaneous push 9/pop → the popped value is the old head, `count` stays 4, and 9 is returned last. Empty plus simultaneous push 7/pop → `count`=1, `rd_data`=7.
6. Push 2 words, assert `rst` for 1 cycle together with `wr_en` → `count`=0, `empty`=1, flags cleared. The next push of 5 yields `rd_data`=5.
